flash_rd_word_packer: RTL and testbench

//  Downstream stage of the SPI flash read engine. Consumes its byte stream.

---
 rtl/flash_rd_word_packer.sv | 250 +++++++++++++++++++++++++
 tb/tb_flash_rd_word_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rd_word_packer.sv
// flash_rd_word_packer
// Downstream stage of the SPI flash read engine. Packs the incoming byte
// stream little-endian into 32-bit words and queues them in a word FIFO
// for the image consumer. Keeps a real-byte count and a mod-2^32 word
// checksum. At end of read, it pads and pushes any partial word, then raises
// done once the FIFO has drained.
//
// Ports
//   system_clk     in   1   single clock, rising edge
//   system_reset   in   1   asynchronous active-high reset
//   start_flag     in   1   pulse: clear everything and begin a new image
//   rd_byte        in   8   byte from the read engine
//   rd_byte_valid  in   1   rd_byte valid (no backpressure upstream)
//   read_finish    in   1   level: image fully read
//   word_data      out  32  FIFO head word (0 while empty)
//   word_valid     out  1   FIFO not empty
//   word_ready     in   1   consumer takes word_data on word_valid&&word_ready
//   byte_count     out  32  real bytes accepted since start (no pad)
//   checksum       out  32  mod-2^32 sum of words pushed into the FIFO
//   overflow       out  1   sticky: a word was dropped on a full FIFO
//   done           out  1   image flushed and FIFO drained
module flash_rd_word_packer #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
    input  logic        system_clk,
    input  logic        system_reset,
    input  logic        start_flag,
    input  logic [7:0]  rd_byte,
    input  logic        rd_byte_valid,
    input  logic        read_finish,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] byte_count,
    output logic [31:0] checksum,
    output logic        overflow,
    output logic        done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [1:0]         byte_idx_r;
    logic [1:0]         byte_idx_next_s;
    logic [23:0]        pack_r;          // bytes 0..2 of the word in progress
    logic [31:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [31:0]        byte_count_r;
    logic [31:0]        checksum_r;
    logic               overflow_r;
    logic               done_r;

    logic               clear_s;
    logic               accept_s;
    logic               push_req_s;
    logic               push_ok_s;
    logic               drop_s;
    logic               pop_s;
    logic               full_s;
    logic [31:0]        push_word_s;

    // Final partial word: keep the idx real bytes, fill the rest with pad.
    function automatic logic [31:0] pad_word(input logic [23:0] pack,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  pad);
        logic [31:0] w;
        case (idx)
            2'd1:    w = {pad, pad, pad, pack[7:0]};
            2'd2:    w = {pad, pad, pack[15:0]};
            2'd3:    w = {pad, pack[23:0]};
            default: w = {pad, pad, pad, pad};
        endcase
        return w;
    endfunction

    assign full_s          = (count_r == FULL_CNT);
    assign pop_s           = (count_r != {CNT_W{1'b0}}) && word_ready;
    // Index after the current byte; only meaningful in COLLECT.
    assign byte_idx_next_s = rd_byte_valid ? (byte_idx_r + 2'd1) : byte_idx_r;

    // Next-state logic and per-cycle push/accept control.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        push_req_s   = 1'b0;
        push_ok_s    = 1'b0;
        drop_s       = 1'b0;
        push_word_s  = 32'd0;
        if (start_flag) begin
            clear_s      = 1'b1;
            state_next_s = ST_COLLECT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_COLLECT: begin
                    accept_s = rd_byte_valid;
                    if (rd_byte_valid && (byte_idx_r == 2'd3)) begin
                        push_req_s  = 1'b1;
                        push_word_s = {rd_byte, pack_r};
                    end else begin
                        push_req_s  = 1'b0;
                    end
                    // A byte arriving with read_finish is taken before leaving.
                    if (read_finish) begin
                        if (byte_idx_next_s == 2'd0) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_FLUSH;
                        end
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end
                ST_FLUSH: begin
                    // The pad word is never dropped: wait here for room.
                    push_req_s  = 1'b1;
                    push_word_s = pad_word(pack_r, byte_idx_r, PAD_BYTE);
                    if (!full_s || pop_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
            // A full FIFO still takes a push if the head leaves this cycle.
            push_ok_s = push_req_s && (!full_s || pop_s);
            drop_s    = push_req_s && !push_ok_s && (state_r == ST_COLLECT);
        end
    end

    // FSM state register.
    always_ff @(posedge system_clk or posedge system_reset) begin
        if (system_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage; contents need no reset since word_data is gated by count.
    always_ff @(posedge system_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge system_clk or posedge system_reset) begin
        if (system_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte packing, byte count, checksum and sticky overflow.
    always_ff @(posedge system_clk or posedge system_reset) begin
        if (system_reset) begin
            byte_idx_r   <= 2'd0;
            pack_r       <= 24'd0;
            byte_count_r <= 32'd0;
            checksum_r   <= 32'd0;
            overflow_r   <= 1'b0;
        end else if (clear_s) begin
            byte_idx_r   <= 2'd0;
            pack_r       <= 24'd0;
            byte_count_r <= 32'd0;
            checksum_r   <= 32'd0;
            overflow_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                byte_idx_r   <= byte_idx_r + 2'd1;
                byte_count_r <= byte_count_r + 32'd1;
                case (byte_idx_r)
                    2'd0:    pack_r[7:0]   <= rd_byte;
                    2'd1:    pack_r[15:8]  <= rd_byte;
                    2'd2:    pack_r[23:16] <= rd_byte;
                    default: pack_r        <= pack_r;   // byte 3 goes straight into the push
                endcase
            end else if (push_ok_s) begin
                byte_idx_r <= 2'd0;                     // pad word consumed the partial
            end
            if (push_ok_s) begin
                checksum_r <= checksum_r + push_word_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // done: DONE state reached and every buffered word handed out.
    always_ff @(posedge system_clk or posedge system_reset) begin
        if (system_reset) begin
            done_r <= 1'b0;
        end else if (clear_s) begin
            done_r <= 1'b0;
        end else if ((state_r == ST_DONE) && (count_r == {CNT_W{1'b0}})) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    assign word_valid = (count_r != {CNT_W{1'b0}});
    assign word_data  = word_valid ? mem_r[rd_ptr_r] : 32'd0;
    assign byte_count = byte_count_r;
    assign checksum   = checksum_r;
    assign overflow   = overflow_r;
    assign done       = done_r;

endmodule

// File: tb/tb_flash_rd_word_packer.sv
module tb_flash_rd_word_packer;

    logic        system_clk = 1'b0;
    logic        system_reset;
    logic        start_flag;
    logic [7:0]  rd_byte;
    logic        rd_byte_valid;
    logic        read_finish;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] byte_count;
    logic [31:0] checksum;
    logic        overflow;
    logic        done;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sum;
    logic [31:0] w;

    flash_rd_word_packer #(.FIFO_DEPTH(16), .PAD_BYTE(8'hFF)) dut (
        .system_clk   (system_clk),
        .system_reset (system_reset),
        .start_flag   (start_flag),
        .rd_byte      (rd_byte),
        .rd_byte_valid(rd_byte_valid),
        .read_finish  (read_finish),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .byte_count   (byte_count),
        .checksum     (checksum),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake must match the next expected word.
    always @(negedge system_clk) begin
        if (!system_reset && !start_flag && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %08h expected none", word_data);
            end else begin
                check("word_data", word_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rd_byte       = b;
        rd_byte_valid = 1'b1;
        tick();
        rd_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] wd, input bit exp_push);
        if (exp_push) exp_q.push_back(wd);
        for (int k = 0; k < 4; k++) begin
            send_byte(wd[8*k +: 8]);
        end
    endtask

    task automatic do_start();
        read_finish = 1'b0;
        start_flag  = 1'b1;
        tick();
        start_flag  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] gen_word(input logic [7:0] base, input int i);
        logic [7:0] b0;
        b0 = base + 8'(4 * i);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        system_reset  = 1'b1;
        start_flag    = 1'b0;
        rd_byte       = 8'd0;
        rd_byte_valid = 1'b0;
        read_finish   = 1'b0;
        word_ready    = 1'b0;
        tick();
        tick();
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_data",  word_data,       32'd0);
        check("rst_byte_count", byte_count,      32'd0);
        check("rst_checksum",   checksum,        32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_done",       32'(done),       32'd0);
        system_reset = 1'b0;
        tick();

        // T1: two full words, consumer always ready
        word_ready = 1'b1;
        do_start();
        send_word(32'h04030201, 1'b1);
        send_word(32'h08070605, 1'b1);
        read_finish = 1'b1;
        wait_done("t1_done");
        check("t1_checksum",   checksum,              32'h0C0A0806);
        check("t1_byte_count", byte_count,            32'd8);
        check("t1_drained",    32'(exp_q.size()),     32'd0);

        // T2: five bytes, final word padded with FF
        do_start();
        send_word(32'h14131211, 1'b1);
        exp_q.push_back(32'hFFFFFF15);
        send_byte(8'h15);
        read_finish = 1'b1;
        wait_done("t2_done");
        check("t2_byte_count", byte_count,            32'd5);
        check("t2_checksum",   checksum,              32'h14131126);
        check("t2_drained",    32'(exp_q.size()),     32'd0);

        // T3: consumer stalled, 17 words -> 16 held, 17th dropped
        word_ready = 1'b0;
        do_start();
        sum = 32'd0;
        for (int i = 0; i < 17; i++) begin
            w = gen_word(8'h01, i);
            if (i == 16) check("t3_no_ovf_at_16", 32'(overflow), 32'd0);
            send_word(w, i < 16);
            if (i < 16) sum = sum + w;
        end
        check("t3_overflow",   32'(overflow),   32'd1);
        check("t3_checksum",   checksum,        sum);
        check("t3_byte_count", byte_count,      32'd68);
        check("t3_head_valid", 32'(word_valid), 32'd1);
        check("t3_head_data",  word_data,       32'h04030201);
        read_finish = 1'b1;
        tick();
        tick();
        tick();
        check("t3_done_waits", 32'(done), 32'd0);
        word_ready = 1'b1;
        wait_done("t3_done");
        check("t3_drained",     32'(exp_q.size()), 32'd0);
        check("t3_ovf_sticky",  32'(overflow),     32'd1);

        // T4: 4th byte together with read_finish -> no pad word
        do_start();
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        check("t4_cks_cleared", checksum,      32'd0);
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        exp_q.push_back(32'hAA232221);
        read_finish = 1'b1;
        send_byte(8'hAA);
        wait_done("t4_done");
        check("t4_byte_count", byte_count,        32'd4);
        check("t4_checksum",   checksum,          32'hAA232221);
        check("t4_drained",    32'(exp_q.size()), 32'd0);

        // T5: reset mid-image, bytes ignored until start
        do_start();
        send_byte(8'h31);
        send_byte(8'h32);
        check("t5_pre_count", byte_count, 32'd2);
        system_reset = 1'b1;
        #1;
        check("t5_rst_count",  byte_count,      32'd0);
        check("t5_rst_valid",  32'(word_valid), 32'd0);
        check("t5_rst_cks",    checksum,        32'd0);
        check("t5_rst_done",   32'(done),       32'd0);
        tick();
        system_reset = 1'b0;
        send_word(32'h44434241, 1'b0);
        check("t5_idle_count", byte_count,      32'd0);
        check("t5_idle_valid", 32'(word_valid), 32'd0);
        do_start();
        send_word(32'h54535251, 1'b1);
        read_finish = 1'b1;
        wait_done("t5_done");
        check("t5_byte_count", byte_count, 32'd4);
        check("t5_checksum",   checksum,   32'h54535251);

        // T6a: checksum wraps modulo 2^32
        do_start();
        send_word(32'hFFFFFFFF, 1'b1);
        send_word(32'h00000002, 1'b1);
        read_finish = 1'b1;
        wait_done("t6a_done");
        check("t6a_checksum", checksum, 32'h00000001);

        // T6b: FIFO full in FLUSH -> stall until the first pop
        word_ready = 1'b0;
        do_start();
        sum = 32'd0;
        for (int i = 0; i < 16; i++) begin
            w = gen_word(8'h80, i);
            send_word(w, 1'b1);
            sum = sum + w;
        end
        exp_q.push_back(32'hFFFFC2C1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        read_finish = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t6b_stall_done", 32'(done),     32'd0);
        check("t6b_stall_cks",  checksum,      sum);
        check("t6b_stall_ovf",  32'(overflow), 32'd0);
        check("t6b_byte_count", byte_count,    32'd66);
        word_ready = 1'b1;
        tick();
        check("t6b_pad_cks", checksum, sum + 32'hFFFFC2C1);
        wait_done("t6b_done");
        check("t6b_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
